// File: rtl/sram_block_mover_pkg.sv
// Shared definitions for the SRAM block mover: FSM state encodings and transfer modes.
package sram_block_mover_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/sram_block_mover.sv
// Bus initiator that copies a word block between two single-port SRAMs or fills a destination range.
// Handshake: i_START is accepted only in IDLE without i_ABORT; o_DONE pulses once on normal completion.
module sram_block_mover
  import sram_block_mover_pkg::*;
#(
  parameter int dw = 8,
  parameter int aw = 10
) (
  input  logic          i_MCLK,
  input  logic          i_RST_n,
  input  logic          i_START,
  input  logic          i_ABORT,
  input  logic          i_MODE,
  input  logic [aw-1:0] i_SRC_BASE,
  input  logic [aw-1:0] i_DST_BASE,
  input  logic [aw-1:0] i_LEN,
  input  logic [dw-1:0] i_FILL_DATA,
  output logic          o_BUSY,
  output logic          o_DONE,
  output logic [aw-1:0] o_SRC_ADDR,
  output logic          o_SRC_CS_n,
  output logic          o_SRC_RD_n,
  input  logic [dw-1:0] i_SRC_DOUT,
  output logic [aw-1:0] o_DST_ADDR,
  output logic [dw-1:0] o_DST_DIN,
  output logic          o_DST_CS_n,
  output logic          o_DST_WR_n,
  output logic [2:0]    o_STATE
);

  state_t        state, state_nxt;
  logic [aw-1:0] cnt, cnt_nxt;
  logic          mode, mode_nxt;
  logic [aw-1:0] src_nxt, dst_nxt;
  logic [dw-1:0] din_nxt;
  logic          src_acc_nxt, dst_acc_nxt;
  logic          busy_nxt, done_nxt;

  assign o_STATE = state;

  // Every output is computed from the state being entered, so strobes are registered with it.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    mode_nxt    = mode;
    src_nxt     = o_SRC_ADDR;
    dst_nxt     = o_DST_ADDR;
    din_nxt     = o_DST_DIN;
    src_acc_nxt = 1'b0;
    dst_acc_nxt = 1'b0;
    busy_nxt    = o_BUSY;
    done_nxt    = 1'b0;

    case (state)
      ST_IDLE: begin
        busy_nxt = 1'b0;
        if (i_START && !i_ABORT) begin
          busy_nxt = 1'b1;
          cnt_nxt  = i_LEN;
          mode_nxt = i_MODE;
          src_nxt  = i_SRC_BASE;
          dst_nxt  = i_DST_BASE;
          if (i_MODE == MODE_FILL) begin
            state_nxt   = ST_WR;
            din_nxt     = i_FILL_DATA;
            dst_acc_nxt = 1'b1;
          end else begin
            state_nxt   = ST_RD;
            src_acc_nxt = 1'b1;
          end
        end
      end
      ST_RD: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        state_nxt   = ST_WR;
        din_nxt     = i_SRC_DOUT;
        dst_acc_nxt = 1'b1;
      end
      ST_WR: begin
        if (cnt == '0) begin
          state_nxt = ST_FIN;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - aw'(1);
          src_nxt = o_SRC_ADDR + aw'(1);
          dst_nxt = o_DST_ADDR + aw'(1);
          if (mode == MODE_FILL) begin
            state_nxt   = ST_WR;
            dst_acc_nxt = 1'b1;
          end else begin
            state_nxt   = ST_RD;
            src_acc_nxt = 1'b1;
          end
        end
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase

    // A strobe already visible still completes at this edge; only the next access is suppressed.
    if (i_ABORT && state != ST_IDLE) begin
      state_nxt   = ST_IDLE;
      src_acc_nxt = 1'b0;
      dst_acc_nxt = 1'b0;
      busy_nxt    = 1'b0;
      done_nxt    = 1'b0;
    end
  end

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      mode       <= MODE_COPY;
      o_SRC_ADDR <= '0;
      o_DST_ADDR <= '0;
      o_DST_DIN  <= '0;
      o_SRC_CS_n <= 1'b1;
      o_SRC_RD_n <= 1'b1;
      o_DST_CS_n <= 1'b1;
      o_DST_WR_n <= 1'b1;
      o_BUSY     <= 1'b0;
      o_DONE     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      mode       <= mode_nxt;
      o_SRC_ADDR <= src_nxt;
      o_DST_ADDR <= dst_nxt;
      o_DST_DIN  <= din_nxt;
      o_SRC_CS_n <= ~src_acc_nxt;
      o_SRC_RD_n <= ~src_acc_nxt;
      o_DST_CS_n <= ~dst_acc_nxt;
      o_DST_WR_n <= ~dst_acc_nxt;
      o_BUSY     <= busy_nxt;
      o_DONE     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_sram_block_mover.sv
// Bench for sram_block_mover: two behavioural posedge SRAMs, a write scoreboard and directed transfers.
module tb_sram_block_mover;
  import sram_block_mover_pkg::*;

  localparam int DW = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start, abort, mode;
  logic [AW-1:0] src_base, dst_base, len;
  logic [DW-1:0] fill_data;
  logic          busy, done;
  logic [AW-1:0] src_addr, dst_addr;
  logic          src_cs_n, src_rd_n, dst_cs_n, dst_wr_n;
  logic [DW-1:0] src_dout = '0;
  logic [DW-1:0] dst_din;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  sram_block_mover #(.dw(DW), .aw(AW)) dut (
    .i_MCLK(clk), .i_RST_n(rst_n), .i_START(start), .i_ABORT(abort), .i_MODE(mode),
    .i_SRC_BASE(src_base), .i_DST_BASE(dst_base), .i_LEN(len), .i_FILL_DATA(fill_data),
    .o_BUSY(busy), .o_DONE(done),
    .o_SRC_ADDR(src_addr), .o_SRC_CS_n(src_cs_n), .o_SRC_RD_n(src_rd_n), .i_SRC_DOUT(src_dout),
    .o_DST_ADDR(dst_addr), .o_DST_DIN(dst_din), .o_DST_CS_n(dst_cs_n), .o_DST_WR_n(dst_wr_n),
    .o_STATE(dbg_state)
  );

  // SRAM models (pol=1): read data and writes are registered on posedge.
  logic [DW-1:0] src_mem [1024];
  logic [DW-1:0] dst_mem [1024];
  logic          dst_clear;

  always @(posedge clk) begin
    if (!src_cs_n && !src_rd_n) src_dout <= src_mem[src_addr];
    if (dst_clear) begin
      for (int i = 0; i < 1024; i++) dst_mem[i] <= 8'hEE;
    end else if (!dst_cs_n && !dst_wr_n) begin
      dst_mem[dst_addr] <= dst_din;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            vectors = 0;
  int            miscompares = 0;
  logic [17:0]   exp_q[$];
  int            done_cnt = 0;
  int            last_run = 0;
  int            e0_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every visible write strobe and polices strobe rules.
  initial begin : monitor
    int   run;
    logic prev_done;
    logic [17:0] want;
    run = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!dst_cs_n && !dst_wr_n) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", dst_addr, dst_din);
        end else begin
          want = exp_q.pop_front();
          check("dst_write", {dst_addr, dst_din}, want);
        end
        run++;
      end else begin
        if (run != 0) last_run = run;
        run = 0;
      end
      if (!src_cs_n || !src_rd_n || !dst_cs_n || !dst_wr_n) begin
        check("strobe_excl", (!src_cs_n || !src_rd_n) && (!dst_cs_n || !dst_wr_n), 0);
        check("strobe_busy", busy, 1);
      end
      if (done) begin
        done_cnt++;
        check("done_width", prev_done, 0);
      end
      prev_done = done;
    end
  end

  task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  // Returns at the negedge after the accepting edge E0; e0_cyc marks that edge.
  task automatic start_xfer(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [AW-1:0] l, input logic [DW-1:0] f);
    @(negedge clk);
    mode = m; src_base = s; dst_base = d; len = l; fill_data = f; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    e0_cyc = cyc;
  endtask

  // Edge count includes E0 itself, so a 4-word copy completes on edge 13.
  task automatic wait_done(input string name, input int exp_edges);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, n >= 3000, 0);
    if (n < 3000) check({name, "_edges"}, cyc - e0_cyc + 1, exp_edges);
    @(negedge clk);
    check({name, "_done_drop"}, done, 0);
    check({name, "_idle"}, dbg_state, ST_IDLE);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int d0;
    start = 0; abort = 0; mode = 0; src_base = 0; dst_base = 0; len = 0; fill_data = 0;
    dst_clear = 1'b1;
    for (int i = 0; i < 1024; i++) src_mem[i] = DW'(i) ^ 8'h5C;
    src_mem[10'h010] = 8'hA5; src_mem[10'h011] = 8'h5A;
    src_mem[10'h012] = 8'hC3; src_mem[10'h013] = 8'h3C;
    repeat (3) @(posedge clk);
    @(negedge clk);
    dst_clear = 1'b0;

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_strobes", {src_cs_n, src_rd_n, dst_cs_n, dst_wr_n}, 4'hF);
    check("rst_src_addr", src_addr, 0);
    check("rst_dst_addr", dst_addr, 0);
    check("rst_din", dst_din, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // Copy four words 0x010 -> 0x200.
    push_write(10'h200, 8'hA5); push_write(10'h201, 8'h5A);
    push_write(10'h202, 8'hC3); push_write(10'h203, 8'h3C);
    start_xfer(MODE_COPY, 10'h010, 10'h200, 10'd3, 8'h00);
    check("copy_busy", busy, 1);
    wait_done("copy4", 13);
    check("copy_mem0", dst_mem[10'h200], 8'hA5);
    check("copy_mem3", dst_mem[10'h203], 8'h3C);
    check("copy_mem_after", dst_mem[10'h204], 8'hEE);
    check("copy_q_empty", exp_q.size(), 0);

    // Fill 256 words with zero at 0x100.
    for (int i = 0; i < 256; i++) push_write(10'h100 + AW'(i), 8'h00);
    start_xfer(MODE_FILL, 10'h000, 10'h100, 10'h0FF, 8'h00);
    wait_done("fill256", 257);
    check("fill_run", last_run, 256);
    check("fill_mem_first", dst_mem[10'h100], 8'h00);
    check("fill_mem_last", dst_mem[10'h1FF], 8'h00);
    check("fill_mem_below", dst_mem[10'h0FF], 8'hEE);
    check("fill_mem_above", dst_mem[10'h200], 8'hA5);
    check("fill_q_empty", exp_q.size(), 0);

    // Copy across the top of the address space.
    push_write(10'h3FE, src_mem[10'h3FE]); push_write(10'h3FF, src_mem[10'h3FF]);
    push_write(10'h000, src_mem[10'h000]); push_write(10'h001, src_mem[10'h001]);
    start_xfer(MODE_COPY, 10'h3FE, 10'h3FE, 10'd3, 8'h00);
    wait_done("wrap", 13);
    check("wrap_mem_3ff", dst_mem[10'h3FF], src_mem[10'h3FF]);
    check("wrap_mem_000", dst_mem[10'h000], src_mem[10'h000]);
    check("wrap_mem_002", dst_mem[10'h002], 8'hEE);

    // A second start while busy is ignored.
    d0 = done_cnt;
    for (int i = 0; i < 6; i++) push_write(10'h280 + AW'(i), src_mem[10'h040 + AW'(i)]);
    start_xfer(MODE_COPY, 10'h040, 10'h280, 10'd5, 8'h00);
    repeat (4) @(negedge clk);
    mode = MODE_FILL; src_base = 10'h100; dst_base = 10'h380; len = 10'd0; fill_data = 8'h99;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", 19);
    repeat (20) @(negedge clk);
    check("busy_start_done_cnt", done_cnt - d0, 1);
    check("busy_start_q_empty", exp_q.size(), 0);
    check("busy_start_no_fill", dst_mem[10'h380], 8'hEE);

    // Abort in the WAIT of word 2 of an 8-word copy.
    d0 = done_cnt;
    push_write(10'h300, src_mem[10'h020]);
    start_xfer(MODE_COPY, 10'h020, 10'h300, 10'd7, 8'h00);
    repeat (4) @(negedge clk);
    check("abort_in_wait", dbg_state, ST_WAIT);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_state", dbg_state, ST_IDLE);
    check("abort_strobes", {src_cs_n, src_rd_n, dst_cs_n, dst_wr_n}, 4'hF);
    repeat (40) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_q_empty", exp_q.size(), 0);
    check("abort_word1", dst_mem[10'h300], src_mem[10'h020]);
    check("abort_word2", dst_mem[10'h301], 8'hEE);

    // Abort together with start in IDLE: nothing starts.
    mode = MODE_FILL; dst_base = 10'h3C0; len = 10'd3; fill_data = 8'h11;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_state", dbg_state, ST_IDLE);
    check("abort_start_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("abort_start_mem", dst_mem[10'h3C0], 8'hEE);

    // Asynchronous reset mid-fill.
    for (int i = 0; i < 10; i++) push_write(AW'(i), 8'h77);
    start_xfer(MODE_FILL, 10'h000, 10'h000, 10'h3FF, 8'h77);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_strobes", {src_cs_n, src_rd_n, dst_cs_n, dst_wr_n}, 4'hF);
    check("async_rst_busy", busy, 0);
    check("async_rst_state", dbg_state, ST_IDLE);
    check("async_rst_dst_addr", dst_addr, 0);
    check("async_rst_din", dst_din, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_fill_q_empty", exp_q.size(), 0);
    check("rst_fill_mem8", dst_mem[10'h008], 8'h77);
    check("rst_fill_mem9", dst_mem[10'h009], 8'hEE);

    // A fresh one-word copy after reset.
    push_write(10'h050, 8'hA5);
    start_xfer(MODE_COPY, 10'h010, 10'h050, 10'd0, 8'h00);
    wait_done("post_reset", 4);
    check("post_reset_mem", dst_mem[10'h050], 8'hA5);
    check("final_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
